dmem_responder: RTL and testbench

//   Memory-side responder for the MEM stage's data access.
//   - Accepts one load/store request per valid/ready handshake.
//   - Returns a response after a fixed, configurable latency.
//   - Handles byte/half/word/double sizing, sign extension and misalignment/range errors.
//   - Sits between the memory access stage and the data memory array; busy drives pipeline stall.

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and the data memory responder.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder: one load/store per handshake, RV64 sizing,
// sign extension and misalignment/range error detection.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  counter, counter_next;
    logic        ready, accept, enter_resp;

    logic        cap_write;
    logic [2:0]  cap_funct3;
    logic [63:0] cap_addr, cap_wdata;

    logic        op_write;
    logic [2:0]  op_funct3;
    logic [63:0] op_addr, op_wdata;

    logic        op_err;
    logic [63:0] rd_word, rd_shift, load_val, wr_shift, merged;
    logic [7:0]  mask8, mask;
    logic [5:0]  bit_off;

    logic [63:0] mem [DEPTH_WORDS];

    assign ready  = (state == IDLE) || (state == RESP);
    assign accept = bus.req_valid && ready;

    assign bus.req_ready  = ready;
    assign bus.resp_valid = (state == RESP);
    assign bus.busy       = (state == WAIT);

    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    counter_next = 4'(LATENCY - 1);
                    state_next   = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                counter_next = counter - 4'd1;
                if (counter == 4'd1) state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP);

    // With single-cycle latency the commit happens on the accept edge itself,
    // so the live bus fields are used instead of the captured copy.
    always_comb begin
        op_write  = cap_write;
        op_funct3 = cap_funct3;
        op_addr   = cap_addr;
        op_wdata  = cap_wdata;
        if (LATENCY == 1) begin
            op_write  = bus.req_write;
            op_funct3 = bus.req_funct3;
            op_addr   = bus.req_addr;
            op_wdata  = bus.req_wdata;
        end
    end

    always_comb begin
        op_err = 1'b0;
        if (op_funct3 == 3'b111)                              op_err = 1'b1;
        if (op_write && op_funct3[2])                         op_err = 1'b1;
        if (op_funct3[1:0] == 2'b01 && op_addr[0])            op_err = 1'b1;
        if (op_funct3[1:0] == 2'b10 && op_addr[1:0] != 2'b00) op_err = 1'b1;
        if (op_funct3 == 3'b011 && op_addr[2:0] != 3'b000)    op_err = 1'b1;
        if (op_addr[63:3] >= 61'(DEPTH_WORDS))                op_err = 1'b1;
    end

    assign bit_off  = {op_addr[2:0], 3'b000};
    assign rd_word  = mem[op_addr[IW+2:3]];
    assign rd_shift = rd_word >> bit_off;
    assign wr_shift = op_wdata << bit_off;

    always_comb begin
        load_val = 64'd0;
        case (op_funct3)
            3'b000:  load_val = {{56{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  load_val = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_val = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b011:  load_val = rd_shift;
            3'b100:  load_val = {56'd0, rd_shift[7:0]};
            3'b101:  load_val = {48'd0, rd_shift[15:0]};
            3'b110:  load_val = {32'd0, rd_shift[31:0]};
            default: load_val = 64'd0;
        endcase
    end

    always_comb begin
        mask8 = 8'h00;
        case (op_funct3[1:0])
            2'b00:   mask8 = 8'h01;
            2'b01:   mask8 = 8'h03;
            2'b10:   mask8 = 8'h0F;
            default: mask8 = 8'hFF;
        endcase
        mask   = mask8 << op_addr[2:0];
        merged = rd_word;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) merged[b*8 +: 8] = wr_shift[b*8 +: 8];
        end
    end

    // Reset on the commit edge suppresses the write, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && op_write && !op_err) begin
            mem[op_addr[IW+2:3]] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            counter        <= 4'd0;
            cap_write      <= 1'b0;
            cap_funct3     <= 3'd0;
            cap_addr       <= 64'd0;
            cap_wdata      <= 64'd0;
            bus.resp_rdata <= 64'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            if (accept) begin
                cap_write  <= bus.req_write;
                cap_funct3 <= bus.req_funct3;
                cap_addr   <= bus.req_addr;
                cap_wdata  <= bus.req_wdata;
            end
            if (enter_resp) begin
                bus.resp_rdata <= (op_write || op_err) ? 64'd0 : load_val;
                bus.resp_err   <= op_err;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=1024, LATENCY=2) with hand-computed expectations.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    dmem_if bus ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Issues one request, then reports the response and the number of cycles
    // (sampled on falling edges) from the accept edge to resp_valid; -1 on timeout.
    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                                 input logic [63:0] wdata, output logic [63:0] rdata,
                                 output logic err, output int lat);
        int waited;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat   = -1;
        rdata = 64'hX;
        err   = 1'bX;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat   = c;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
        end
    endtask

    logic [63:0] rd;
    logic        er;
    int          lt;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("rst_rdata",      bus.resp_rdata,      64'd0);
        checkOutput("rst_err",        64'(bus.resp_err),   64'd0);
        checkOutput("rst_busy",       64'(bus.busy),       64'd0);
        checkOutput("rst_ready",      64'(bus.req_ready),  64'd1);
        rst = 1'b0;

        applyStimulus(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd, er, lt);
        checkOutput("sd_lat",   64'(lt), 64'(LAT));
        checkOutput("sd_err",   64'(er), 64'd0);
        checkOutput("sd_rdata", rd,      64'd0);
        applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, rd, er, lt);
        checkOutput("ld_lat",   64'(lt), 64'(LAT));
        checkOutput("ld_rdata", rd,      64'h1122334455667788);
        checkOutput("ld_err",   64'(er), 64'd0);

        applyStimulus(1'b1, 3'b011, 64'h0, 64'h0706050403020100, rd, er, lt);
        applyStimulus(1'b1, 3'b000, 64'h3, 64'h5555555555555580, rd, er, lt);
        checkOutput("sb_err", 64'(er), 64'd0);
        applyStimulus(1'b0, 3'b000, 64'h3, 64'd0, rd, er, lt);
        checkOutput("lb_rdata", rd, 64'hFFFFFFFFFFFFFF80);
        applyStimulus(1'b0, 3'b100, 64'h3, 64'd0, rd, er, lt);
        checkOutput("lbu_rdata", rd, 64'h0000000000000080);
        applyStimulus(1'b0, 3'b011, 64'h0, 64'd0, rd, er, lt);
        checkOutput("sb_other_bytes", rd, 64'h0706050480020100);

        applyStimulus(1'b0, 3'b001, 64'h2, 64'd0, rd, er, lt);
        checkOutput("lh_rdata", rd, 64'hFFFFFFFFFFFF8002);
        applyStimulus(1'b0, 3'b110, 64'h4, 64'd0, rd, er, lt);
        checkOutput("lwu_rdata", rd, 64'h0000000007060504);
        applyStimulus(1'b0, 3'b101, 64'h6, 64'd0, rd, er, lt);
        checkOutput("lhu_rdata", rd, 64'h0000000000000706);

        applyStimulus(1'b1, 3'b010, 64'h2, 64'h00000000DEADBEEF, rd, er, lt);
        checkOutput("sw_mis_err",   64'(er), 64'd1);
        checkOutput("sw_mis_rdata", rd,      64'd0);
        applyStimulus(1'b0, 3'b011, 64'h0, 64'd0, rd, er, lt);
        checkOutput("sw_mis_nowrite", rd, 64'h0706050480020100);
        applyStimulus(1'b0, 3'b001, 64'h1, 64'd0, rd, er, lt);
        checkOutput("lh_mis_err", 64'(er), 64'd1);

        applyStimulus(1'b0, 3'b011, 64'(DEPTH * 8), 64'd0, rd, er, lt);
        checkOutput("range_err",   64'(er), 64'd1);
        checkOutput("range_rdata", rd,      64'd0);
        applyStimulus(1'b0, 3'b011, 64'h8000000000000010, 64'd0, rd, er, lt);
        checkOutput("range_hibit_err", 64'(er), 64'd1);
        applyStimulus(1'b0, 3'b011, 64'((DEPTH - 1) * 8), 64'd0, rd, er, lt);
        checkOutput("range_last_ok", 64'(er), 64'd0);
        applyStimulus(1'b0, 3'b111, 64'h0, 64'd0, rd, er, lt);
        checkOutput("f3_111_err", 64'(er), 64'd1);
        applyStimulus(1'b1, 3'b100, 64'h0, 64'hFF, rd, er, lt);
        checkOutput("st_f3_100_err", 64'(er), 64'd1);
        applyStimulus(1'b0, 3'b011, 64'h0, 64'd0, rd, er, lt);
        checkOutput("st_f3_100_nowrite", rd, 64'h0706050480020100);

        // Back-to-back: req_valid stays high across three loads.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b011;
        bus.req_addr   = 64'h10;
        begin
            logic [63:0] b2b_addr [3] = '{64'h10, 64'h0, 64'h3};
            logic [2:0]  b2b_f3   [3] = '{3'b011, 3'b011, 3'b100};
            logic [63:0] b2b_exp  [3] = '{64'h1122334455667788, 64'h0706050480020100, 64'h80};
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                @(negedge clk);
                checkOutput($sformatf("b2b_busy_%0d", i),  64'(bus.busy),      64'd1);
                checkOutput($sformatf("b2b_ready_%0d", i), 64'(bus.req_ready), 64'd0);
                if (i < 2) begin
                    bus.req_addr   = b2b_addr[i+1];
                    bus.req_funct3 = b2b_f3[i+1];
                end else begin
                    bus.req_valid = 1'b0;
                end
                @(negedge clk);
                checkOutput($sformatf("b2b_valid_%0d", i), 64'(bus.resp_valid), 64'd1);
                checkOutput($sformatf("b2b_rdata_%0d", i), bus.resp_rdata,      b2b_exp[i]);
            end
        end
        @(negedge clk);
        checkOutput("b2b_idle_after", 64'(bus.resp_valid), 64'd0);

        // Reset while the store is waiting to commit.
        applyStimulus(1'b1, 3'b011, 64'h8, 64'h0123456789ABCDEF, rd, er, lt);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b011;
        bus.req_addr   = 64'h8;
        bus.req_wdata  = 64'hAA;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstmid_no_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("rstmid_not_busy", 64'(bus.busy),       64'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rstmid_still_quiet", 64'(bus.resp_valid), 64'd0);
        end
        applyStimulus(1'b0, 3'b011, 64'h8, 64'd0, rd, er, lt);
        checkOutput("rstmid_old_value", rd, 64'h0123456789ABCDEF);
        checkOutput("rstmid_ld_lat", 64'(lt), 64'(LAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
